// File: rtl/weight_enum_12bit_if.sv
// Handshake bundle between the weight enumerator and its consumer.
// The slave modport is the enumerator side; master is the requester/consumer side.
interface weight_enum_12bit_if #(
   parameter int W  = 12,
   parameter int KW = 4
);
   logic          start;
   logic [KW-1:0] k;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  word;
   logic          last;
   logic [9:0]    idx;
   logic          err;

   modport slave (
      input  start, k, out_ready,
      output busy, out_valid, word, last, idx, err
   );

   modport master (
      output start, k, out_ready,
      input  busy, out_valid, word, last, idx, err
   );
endinterface

// File: rtl/weight_enum_12bit.sv
// Enumerates every 12-bit word of Hamming weight k in increasing order,
// one word per valid/ready handshake, using a combinational Gosper step.
module weight_enum_12bit #(
   parameter int W  = 12,
   parameter int KW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   weight_enum_12bit_if.slave   bus_io
);
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  word_q, word_d;
   logic [9:0]    idx_q, idx_d;
   logic [KW-1:0] k_q, k_d;
   logic          err_q, err_d;

   logic          k_ok;
   logic          hs;
   logic          last_w;
   logic [W-1:0]  top_mask;
   logic [W-1:0]  init_word;
   logic [W-1:0]  succ;
   logic [W-1:0]  low_bit;
   logic [W:0]    ripple;
   logic [W:0]    changed;
   logic [3:0]    tz;

   assign k_ok      = (bus_io.k <= KW'(W));
   // Final word has all k ones packed at the top; k=0/12 have a single word.
   assign top_mask  = ~({W{1'b1}} >> k_q);
   assign init_word = {W{1'b1}} >> (KW'(W) - bus_io.k);
   assign last_w    = (state_q == EMIT) &&
                      ((k_q == '0) || (k_q == KW'(W)) || (word_q == top_mask));
   assign hs        = (state_q == EMIT) && bus_io.out_ready;

   // Gosper successor of the current word, 13-bit intermediate sum
   always_comb begin
      low_bit = word_q & (~word_q + W'(1));
      ripple  = {1'b0, word_q} + {1'b0, low_bit};
      tz      = 4'd0;
      for (int i = W - 1; i >= 0; i--) begin
         if (word_q[i]) tz = 4'(i);
      end
      changed = (ripple ^ {1'b0, word_q}) >> (tz + 4'd2);
      succ    = ripple[W-1:0] | changed[W-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: start only honoured in IDLE, leave on final handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus_io.start && k_ok) state_d = EMIT;
         EMIT: if (hs && last_w)         state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
         k_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
         k_q    <= k_d;
         err_q  <= err_d;
      end
   end

   // Datapath next values: load on accepted start, advance on non-final handshake
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      k_d    = k_q;
      err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               if (k_ok) begin
                  k_d    = bus_io.k;
                  idx_d  = '0;
                  word_d = init_word;
               end else begin
                  err_d  = 1'b1;
               end
            end
         end
         EMIT: begin
            if (hs && !last_w) begin
               word_d = succ;
               idx_d  = idx_q + 10'd1;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      bus_io.busy      = (state_q == EMIT);
      bus_io.out_valid = (state_q == EMIT);
      bus_io.word      = word_q;
      bus_io.idx       = idx_q;
      bus_io.last      = last_w;
      bus_io.err       = err_q;
   end
endmodule

// File: tb/tb_weight_enum_12bit.sv
// Bench for weight_enum_12bit: table of full enumerations plus directed
// corner sequences (reset, bad k, random back-pressure, mid-run reset, held start).
module tb_weight_enum_12bit;
   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   weight_enum_12bit_if bus ();

   weight_enum_12bit dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  k;
      int          n;
      logic [11:0] first;
      logic [11:0] final_w;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [11:0] first_pop(input int kk);
      for (int v = 0; v < 4096; v++)
         if ($countones(12'(v)) == kk) return 12'(v);
      return 12'h000;
   endfunction

   function automatic logic [11:0] next_pop(input logic [11:0] prev, input int kk);
      for (int v = int'(prev) + 1; v < 4096; v++)
         if ($countones(12'(v)) == kk) return 12'(v);
      return 12'h000;
   endfunction

   // Runs one enumeration from IDLE; entered and left at #1 after a rising edge.
   task automatic run_enum(input logic [3:0] kk, input bit rnd, input bit hold,
                           input int exp_n, input logic [11:0] exp_first,
                           input logic [11:0] exp_final, input string tag);
      logic [11:0] exp_w, fw, hw;
      logic [9:0]  fi, hi;
      logic        hl, r, done, prev_stall;
      int cnt, b_seq, b_idx, b_pop, b_last, b_stab, b_vld;
      cnt = 0; b_seq = 0; b_idx = 0; b_pop = 0; b_last = 0; b_stab = 0; b_vld = 0;
      done = 0; prev_stall = 0; fw = '0; fi = '0; hw = '0; hi = '0; hl = 0;
      bus.k = kk; bus.start = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      check({tag, " valid_after_start"}, 32'(bus.out_valid), 32'd1);
      check({tag, " first_word"}, 32'(bus.word), 32'(exp_first));
      exp_w = first_pop(int'(kk));
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         if (prev_stall && (bus.word !== hw || bus.idx !== hi || bus.last !== hl)) b_stab++;
         if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) b_vld++;
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = r;
         if (r) begin
            if (bus.word !== exp_w) b_seq++;
            if (bus.idx !== cnt[9:0]) b_idx++;
            if ($countones(bus.word) != int'(kk)) b_pop++;
            if (bus.last !== ((cnt + 1) == exp_n)) b_last++;
            fw = bus.word; fi = bus.idx; cnt++;
            if (bus.last === 1'b1) done = 1;
            else exp_w = next_pop(exp_w, int'(kk));
         end
         prev_stall = !r; hw = bus.word; hi = bus.idx; hl = bus.last;
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      check({tag, " handshakes"}, 32'(cnt), 32'(exp_n));
      check({tag, " seq_errs"}, 32'(b_seq), 32'd0);
      check({tag, " idx_errs"}, 32'(b_idx + b_last), 32'd0);
      check({tag, " pop_errs"}, 32'(b_pop), 32'd0);
      check({tag, " valid_errs"}, 32'(b_vld), 32'd0);
      if (rnd) check({tag, " stall_errs"}, 32'(b_stab), 32'd0);
      check({tag, " final_word"}, 32'(fw), 32'(exp_final));
      check({tag, " final_idx"}, 32'(fi), 32'(exp_n - 1));
      check({tag, " valid_after_last"}, 32'(bus.out_valid), 32'd0);
      check({tag, " word_held"}, 32'(bus.word), 32'(exp_final));
      check({tag, " idx_held"}, 32'(bus.idx), 32'(exp_n - 1));
   endtask

   initial begin
      logic [11:0] w, wsave;
      vecs[0] = '{k: 4'd0,  n: 1,   first: 12'h000, final_w: 12'h000};
      vecs[1] = '{k: 4'd1,  n: 12,  first: 12'h001, final_w: 12'h800};
      vecs[2] = '{k: 4'd2,  n: 66,  first: 12'h003, final_w: 12'hC00};
      vecs[3] = '{k: 4'd5,  n: 792, first: 12'h01F, final_w: 12'hF80};
      vecs[4] = '{k: 4'd11, n: 12,  first: 12'h7FF, final_w: 12'hFFE};
      vecs[5] = '{k: 4'd12, n: 1,   first: 12'hFFF, final_w: 12'hFFF};

      // reset with start asserted: start must be ignored
      rst = 1'b1; bus.start = 1'b1; bus.k = 4'd3; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst valid", 32'(bus.out_valid), 32'd0);
      check("rst last", 32'(bus.last), 32'd0);
      check("rst err", 32'(bus.err), 32'd0);
      check("rst word", 32'(bus.word), 32'h000);
      check("rst idx", 32'(bus.idx), 32'd0);
      @(posedge clk); #1;
      check("idle valid", 32'(bus.out_valid), 32'd0);

      for (int i = 0; i < 6; i++)
         run_enum(vecs[i].k, 1'b0, 1'b0, vecs[i].n, vecs[i].first, vecs[i].final_w,
                  $sformatf("k%0d", vecs[i].k));

      // out-of-range k: one-cycle err, nothing else moves
      wsave = bus.word;
      bus.k = 4'd13; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("k13 err", 32'(bus.err), 32'd1);
      check("k13 valid", 32'(bus.out_valid), 32'd0);
      check("k13 busy", 32'(bus.busy), 32'd0);
      check("k13 word", 32'(bus.word), 32'(wsave));
      @(posedge clk); #1;
      check("k13 err_pulse", 32'(bus.err), 32'd0);
      run_enum(4'd1, 1'b0, 1'b0, 12, 12'h001, 12'h800, "after_err k1");

      // random back-pressure
      run_enum(4'd6, 1'b1, 1'b0, 924, 12'h03F, 12'hFC0, "rand k6");

      // reset in the middle of a k=3 run
      bus.k = 4'd3; bus.start = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      w = first_pop(3);
      repeat (10) w = next_pop(w, 3);
      check("midrst idx10", 32'(bus.idx), 32'd10);
      check("midrst word10", 32'(bus.word), 32'(w));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.out_ready = 1'b0;
      check("midrst valid", 32'(bus.out_valid), 32'd0);
      check("midrst word", 32'(bus.word), 32'h000);
      check("midrst idx", 32'(bus.idx), 32'd0);
      run_enum(4'd3, 1'b0, 1'b0, 220, 12'h007, 12'hE00, "restart k3");

      // start held across a whole k=1 run
      run_enum(4'd1, 1'b0, 1'b1, 12, 12'h001, 12'h800, "held k1");
      @(posedge clk); #1;
      check("held reenter valid", 32'(bus.out_valid), 32'd1);
      check("held reenter word", 32'(bus.word), 32'h001);
      check("held reenter idx", 32'(bus.idx), 32'd0);
      bus.start = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("final rst valid", 32'(bus.out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
